// File: rtl/pixels_blk_former.sv
// pixels_blk_former: raster-to-block former for the encoder front end.
// Stores the top row of each 2-line block-row in a line RAM, then merges it with the
// bottom row as it streams in and emits packed 8x2 blocks (3 components, 14-bit samples).
module pixels_blk_former #(
    parameter int unsigned MAX_SLICE_WIDTH  = 2560,
    parameter int unsigned MAX_SLICE_HEIGHT = 4096
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                sos,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  slice_width,
    input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] slice_height,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [143:0]                        in_data,
    output logic                                blk_valid,
    input  logic                                blk_ready,
    output logic [671:0]                        blk_data,
    output logic                                blk_first_in_row,
    output logic                                blk_last_in_row,
    output logic                                blk_last_in_slice
);

    localparam int unsigned WW    = $clog2(MAX_SLICE_WIDTH);
    localparam int unsigned HW    = $clog2(MAX_SLICE_HEIGHT);
    localparam int unsigned Depth = MAX_SLICE_WIDTH >> 2;
    localparam int unsigned CW    = $clog2(Depth);
    localparam int unsigned BW    = $clog2(MAX_SLICE_HEIGHT >> 1);

    typedef enum logic [1:0] {StIdle, StTop, StBot} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [BW-1:0]   brow_q, brow_d;
    logic [WW-1:0]   width_q;
    logic [HW-1:0]   height_q;
    logic [CW-1:0]   col_last;
    logic [BW-1:0]   brow_last;

    logic            kill;
    logic            accept;
    logic            top_wr;
    logic            bot_acc;
    logic            is_last_col;
    logic            is_last_brow;

    logic [143:0]    mem [Depth];
    logic [143:0]    rd_data_q;

    logic            s1_valid_q;
    logic            s1_odd_q;
    logic [143:0]    s1_data_q;
    logic [2:0]      s1_flags_q;

    logic [671:0]    asm_q, asm_d;
    logic            blk_load;

    logic            blk_valid_q;
    logic [671:0]    blk_data_q;
    logic [2:0]      blk_flags_q;

    // Rounding up is a no-op for legal (multiple-of-8 / even) sizes.
    assign col_last  = CW'((width_q + WW'(3)) >> 2) - CW'(1);
    assign brow_last = BW'((height_q + HW'(1)) >> 1) - BW'(1);

    assign kill         = flush | sos;
    assign accept       = in_valid & in_ready;
    assign top_wr       = accept & (state_q == StTop) & ~rst & ~kill;
    assign bot_acc      = accept & (state_q == StBot) & ~rst & ~kill;
    assign is_last_col  = (col_q == col_last);
    assign is_last_brow = (brow_q == brow_last);

    // Input handshake: odd bottom beats wait until the output register can take a block.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            StTop:   in_ready = 1'b1;
            StBot:   in_ready = ~col_q[0] | ~blk_valid_q | blk_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Next-state: beat / block-row counters and FSM, with flush over sos.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        brow_d  = brow_q;
        case (state_q)
            StTop: begin
                if (accept) begin
                    if (is_last_col) begin
                        col_d   = '0;
                        state_d = StBot;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StBot: begin
                if (accept) begin
                    if (is_last_col) begin
                        col_d = '0;
                        if (is_last_brow) begin
                            state_d = StIdle;
                        end else begin
                            brow_d  = brow_q + BW'(1);
                            state_d = StTop;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
        if (flush) begin
            state_d = StIdle;
            col_d   = '0;
            brow_d  = '0;
        end else if (sos) begin
            state_d = StTop;
            col_d   = '0;
            brow_d  = '0;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            brow_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            brow_q  <= brow_d;
        end
    end

    // Slice geometry is captured at sos and held for the whole slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q  <= '0;
            height_q <= '0;
        end else if (sos && !flush) begin
            width_q  <= slice_width;
            height_q <= slice_height;
        end
    end

    // Top-row line buffer: write port fed by TOP beats, registered read port by BOT beats.
    always_ff @(posedge clk) begin
        if (top_wr) begin
            mem[col_q] <= in_data;
        end
        if (bot_acc) begin
            rd_data_q <= mem[col_q];
        end
    end

    // Stage 1 valid: cleared by any command so an in-flight half block is dropped.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= bot_acc;
        end
    end

    // Stage 1 payload: bottom-row beat, its parity and the block flags it would carry.
    always_ff @(posedge clk) begin
        if (bot_acc) begin
            s1_odd_q   <= col_q[0];
            s1_data_q  <= in_data;
            s1_flags_q <= {col_q == CW'(1), is_last_col, is_last_col & is_last_brow};
        end
    end

    // Stage 2 merge: drop the RAM (top) and registered (bottom) pixels into the active half.
    always_comb begin
        asm_d = asm_q;
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 4; p++) begin
                if (s1_odd_q) begin
                    asm_d[(c*16 + 4 + p)*14 +: 14]     = {2'b00, rd_data_q[(c*4 + p)*12 +: 12]};
                    asm_d[(c*16 + 8 + 4 + p)*14 +: 14] = {2'b00, s1_data_q[(c*4 + p)*12 +: 12]};
                end else begin
                    asm_d[(c*16 + p)*14 +: 14]         = {2'b00, rd_data_q[(c*4 + p)*12 +: 12]};
                    asm_d[(c*16 + 8 + p)*14 +: 14]     = {2'b00, s1_data_q[(c*4 + p)*12 +: 12]};
                end
            end
        end
    end

    assign blk_load = s1_valid_q & s1_odd_q;

    // Left half of the block under assembly; the odd beat completes it directly.
    always_ff @(posedge clk) begin
        if (s1_valid_q && !s1_odd_q) begin
            asm_q <= asm_d;
        end
    end

    // Output register: holds until consumed; a same-cycle load wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_valid_q <= 1'b0;
            blk_data_q  <= '0;
            blk_flags_q <= '0;
        end else if (kill) begin
            blk_valid_q <= 1'b0;
            blk_flags_q <= '0;
        end else if (blk_load) begin
            blk_valid_q <= 1'b1;
            blk_data_q  <= asm_d;
            blk_flags_q <= s1_flags_q;
        end else if (blk_ready) begin
            blk_valid_q <= 1'b0;
        end
    end

    assign blk_valid         = blk_valid_q;
    assign blk_data          = blk_data_q;
    assign blk_first_in_row  = blk_flags_q[2];
    assign blk_last_in_row   = blk_flags_q[1];
    assign blk_last_in_slice = blk_flags_q[0];

endmodule

// File: tb/tb_pixels_blk_former.sv
// Bench for pixels_blk_former: directed slices, scoreboard of expected blocks.
module tb_pixels_blk_former;

    localparam int MW = 2560;
    localparam int MH = 4096;

    logic                    clk = 1'b0;
    logic                    rst, flush, sos;
    logic [$clog2(MW)-1:0]   slice_width;
    logic [$clog2(MH)-1:0]   slice_height;
    logic                    in_valid, in_ready;
    logic [143:0]            in_data;
    logic                    blk_valid, blk_ready;
    logic [671:0]            blk_data;
    logic                    blk_first_in_row, blk_last_in_row, blk_last_in_slice;

    always #5 clk = ~clk;

    pixels_blk_former #(
        .MAX_SLICE_WIDTH  (MW),
        .MAX_SLICE_HEIGHT (MH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .sos               (sos),
        .slice_width       (slice_width),
        .slice_height      (slice_height),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .blk_valid         (blk_valid),
        .blk_ready         (blk_ready),
        .blk_data          (blk_data),
        .blk_first_in_row  (blk_first_in_row),
        .blk_last_in_row   (blk_last_in_row),
        .blk_last_in_slice (blk_last_in_slice)
    );

    typedef struct {
        logic [671:0] data;
        logic [2:0]   flags;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           n_blk = 0;
    int           first_valid_cyc = -1;
    int           last_acc_cyc = -1;
    int           stall_seen = 0;
    int           stall_cnt = 0;
    bit           s_valid, s_ready, s_in_ready;
    bit           prev_hold = 1'b0;
    logic [671:0] prev_data;
    logic [2:0]   prev_flags;
    bit           hold_mode = 1'b0;
    bit           hold_count = 1'b0;

    task automatic chk(input string tag, input logic [671:0] obs, input logic [671:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int c, input int x, input int y, input int seed);
        return 12'(c*1000 + y*300 + x*7 + seed*13);
    endfunction

    function automatic logic [671:0] exp_blk(input int bx, input int by, input int seed);
        logic [671:0] e;
        e = '0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 2; r++)
                for (int x = 0; x < 8; x++)
                    e[(c*16 + r*8 + x)*14 +: 14] = {2'b00, pix(c, bx*8 + x, by*2 + r, seed)};
        return e;
    endfunction

    // One clock: sample and score outputs at the falling edge, then step past the rising edge.
    task automatic cycle(output bit acc);
        exp_t e;
        @(negedge clk);
        cyc++;
        s_valid    = blk_valid;
        s_ready    = blk_ready;
        s_in_ready = in_ready;
        acc = in_valid && in_ready && !rst && !flush && !sos;
        if (prev_hold) begin
            chk("hold_valid", blk_valid, 1'b1);
            chk("hold_data", blk_data, prev_data);
            chk("hold_flags", {blk_first_in_row, blk_last_in_row, blk_last_in_slice}, prev_flags);
        end
        if (blk_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (blk_valid === 1'b1 && blk_ready && !rst) begin
            if (sb.size() == 0) begin
                chk("blk_extra", blk_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                n_blk++;
                chk("blk_data", blk_data, e.data);
                chk("blk_flags", {blk_first_in_row, blk_last_in_row, blk_last_in_slice}, e.flags);
            end
        end
        prev_hold  = (blk_valid === 1'b1) && !blk_ready && !rst && !flush && !sos;
        prev_data  = blk_data;
        prev_flags = {blk_first_in_row, blk_last_in_row, blk_last_in_slice};
        if (hold_mode && !hold_count && blk_valid === 1'b1) begin
            hold_count = 1'b1;
            stall_cnt  = 10;
        end
        @(posedge clk);
        #1;
        if (hold_count) begin
            stall_cnt--;
            if (stall_cnt == 0) begin
                blk_ready  = 1'b1;
                hold_mode  = 1'b0;
                hold_count = 1'b0;
            end
        end
    endtask

    task automatic start(input int w, input int h);
        bit acc;
        sos          = 1'b1;
        slice_width  = 12'(w);
        slice_height = 12'(h);
        cycle(acc);
        sos = 1'b0;
    endtask

    // Stream a raster slice (stopping after max_beats if >= 0); push expected blocks as
    // each odd bottom beat is accepted.
    task automatic send(input int w, input int h, input int seed, input int max_beats);
        int   n;
        bit   acc;
        bit   exp_rdy;
        exp_t e;
        n = 0;
        for (int y = 0; y < h; y++) begin
            for (int b = 0; b < w/4; b++) begin
                if (n == max_beats) begin
                    in_valid = 1'b0;
                    return;
                end
                in_valid = 1'b1;
                for (int c = 0; c < 3; c++)
                    for (int p = 0; p < 4; p++)
                        in_data[(c*4 + p)*12 +: 12] = pix(c, b*4 + p, y, seed);
                acc = 1'b0;
                for (int k = 0; k < 200 && !acc; k++) begin
                    cycle(acc);
                    exp_rdy = (y % 2 == 0) || (b % 2 == 0) || !s_valid || s_ready;
                    chk("in_ready", s_in_ready, exp_rdy);
                    if (!s_in_ready) stall_seen++;
                end
                if (!acc) begin
                    chk("beat_timeout", s_in_ready, 1'b1);
                    in_valid = 1'b0;
                    return;
                end
                n++;
                last_acc_cyc = cyc;
                if (y % 2 == 1 && b % 2 == 1) begin
                    e.data  = exp_blk(b/2, y/2, seed);
                    e.flags[2] = (b/2 == 0);
                    e.flags[1] = (b/2 == w/8 - 1);
                    e.flags[0] = (b/2 == w/8 - 1) && (y/2 == h/2 - 1);
                    sb.push_back(e);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0 && blk_valid !== 1'b1) break;
            cycle(acc);
        end
        chk("drain_empty", sb.size(), 0);
        chk("drain_valid", blk_valid, 1'b0);
    endtask

    initial begin
        bit acc;
        rst          = 1'b1;
        flush        = 1'b0;
        sos          = 1'b0;
        slice_width  = '0;
        slice_height = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        blk_ready    = 1'b1;
        repeat (3) cycle(acc);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_blk_data", blk_data, '0);
        chk("rst_flags", {blk_first_in_row, blk_last_in_row, blk_last_in_slice}, 3'b000);

        // Basic 8x2 block, latency and return to idle
        first_valid_cyc = -1;
        n_blk = 0;
        start(8, 2);
        send(8, 2, 0, -1);
        drain();
        chk("basic_latency", first_valid_cyc - last_acc_cyc, 2);
        chk("basic_count", n_blk, 1);
        chk("basic_idle_rdy", in_ready, 1'b0);

        // Multi-block, multi-row
        n_blk = 0;
        start(32, 4);
        send(32, 4, 1, -1);
        drain();
        chk("multi_count", n_blk, 8);

        // Backpressure on the first block
        n_blk      = 0;
        stall_seen = 0;
        hold_mode  = 1'b1;
        blk_ready  = 1'b0;
        start(32, 4);
        send(32, 4, 2, -1);
        drain();
        chk("bp_count", n_blk, 8);
        chk("bp_stalled", stall_seen > 0, 1'b1);
        chk("bp_ready_restored", blk_ready, 1'b1);

        // Maximum width
        n_blk = 0;
        start(MW, 2);
        send(MW, 2, 3, -1);
        drain();
        chk("maxw_count", n_blk, MW/8);

        // Flush after 3 bottom beats
        n_blk = 0;
        start(32, 4);
        send(32, 4, 4, 11);
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0;
        chk("flush_blk_valid", blk_valid, 1'b0);
        chk("flush_idle_rdy", in_ready, 1'b0);
        chk("flush_sb_empty", sb.size(), 0);
        chk("flush_count", n_blk, 1);
        n_blk = 0;
        start(16, 2);
        send(16, 2, 5, -1);
        drain();
        chk("post_flush_count", n_blk, 2);

        // sos while in TOP restarts the slice (with new geometry)
        n_blk = 0;
        start(32, 4);
        send(32, 4, 6, 3);
        start(16, 4);
        send(16, 4, 7, -1);
        drain();
        chk("resos_count", n_blk, 4);

        // Reset while in BOT
        start(16, 4);
        send(16, 4, 8, 5);
        rst = 1'b1;
        cycle(acc);
        rst = 1'b0;
        chk("mrst_in_ready", in_ready, 1'b0);
        chk("mrst_blk_valid", blk_valid, 1'b0);
        chk("mrst_blk_data", blk_data, '0);
        chk("mrst_flags", {blk_first_in_row, blk_last_in_row, blk_last_in_slice}, 3'b000);
        chk("mrst_sb_empty", sb.size(), 0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(acc);
            chk("mrst_idle_hold", s_in_ready, 1'b0);
        end
        in_valid = 1'b0;
        n_blk = 0;
        start(8, 2);
        send(8, 2, 9, -1);
        drain();
        chk("post_rst_count", n_blk, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired: checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

endmodule
